// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bundle.
// One outstanding request; the response comes back on rsp_valid.
interface fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer between branch resolution and decode.
// IDLE -> REQ -> WAIT -> OUT -> REQ, one request in flight.
module fetch_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] INC      = 3'b100,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall,
  fetch_sequencer_if.master imem,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    OUT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic             kill;

  localparam logic [WIDTH-1:0] STEP =
    {{(WIDTH-3){1'b0}}, INC};

  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_req_addr  = pc;
  assign instr_valid         = (state == OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC[WIDTH-1:0];
      kill     <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (PCsrc) pc <= branch_target;
          state <= REQ;
        end
        REQ: begin
          // a redirect on the accept cycle leaves a stale word in flight
          if (PCsrc) pc <= branch_target;
          if (imem.imem_req_ready) begin
            kill  <= PCsrc;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (PCsrc) begin
            pc   <= branch_target;
            kill <= 1'b1;
          end
          if (imem.imem_rsp_valid) begin
            if (kill || PCsrc) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              instr    <= imem.imem_rsp_data;
              instr_pc <= pc;
              pc       <= pc + STEP;
              state    <= OUT;
            end
          end
        end
        OUT: begin
          if (PCsrc) begin
            pc    <= branch_target;
            state <= REQ;
          end else if (!stall) begin
            state <= REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses
// and delivered PCs are queued; monitors pop and compare.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst1 = 1'b1;
  logic        PCsrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        pc1src = 1'b0;
  logic [31:0] bt1 = '0;
  logic        stall1 = 1'b0;
  logic        iv1;
  logic [31:0] ins1;
  logic [31:0] ipc1;

  int npass = 0;
  int ntot  = 0;
  int lat   = 1;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp1[$];

  fetch_sequencer_if #(.WIDTH(32)) i0 ();
  fetch_sequencer_if #(.WIDTH(32)) i1 ();

  fetch_sequencer #(.WIDTH(32), .INC(3'b100),
    .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc),
    .branch_target(branch_target), .stall(stall),
    .imem(i0), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc)
  );

  fetch_sequencer #(.WIDTH(32), .INC(3'b100),
    .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst1), .PCsrc(pc1src),
    .branch_target(bt1), .stall(stall1),
    .imem(i1), .instr_valid(iv1),
    .instr(ins1), .instr_pc(ipc1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s act=%h exp=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // memory model for dut, latency lat cycles
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    i0.imem_req_ready = 1'b0;
    i0.imem_rsp_valid = 1'b0;
    i0.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (i0.imem_req_valid && i0.imem_req_ready) begin
        pend  = 1'b1;
        paddr = i0.imem_req_addr;
        cnt   = lat - 1;
      end
      @(posedge clk);
      #1;
      i0.imem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          i0.imem_rsp_valid = 1'b1;
          i0.imem_rsp_data  = f(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // zero-wait memory for the wrap instance
  initial begin
    logic a;
    i1.imem_req_ready = 1'b1;
    i1.imem_rsp_valid = 1'b0;
    i1.imem_rsp_data  = 32'h0000_0013;
    forever begin
      @(negedge clk);
      a = i1.imem_req_valid && i1.imem_req_ready;
      @(posedge clk);
      #1;
      i1.imem_rsp_valid = a;
    end
  end

  // request monitor
  initial forever begin
    @(negedge clk);
    if (i0.imem_req_valid && i0.imem_req_ready) begin
      if (exp_addr.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_req act=%h exp=none",
                 i0.imem_req_addr);
      end else begin
        chk("req_addr", i0.imem_req_addr,
            exp_addr.pop_front());
      end
    end
  end

  // wrap-instance request monitor
  initial forever begin
    @(negedge clk);
    if (i1.imem_req_valid && i1.imem_req_ready &&
        exp1.size() != 0)
      chk("wrap_addr", i1.imem_req_addr,
          exp1.pop_front());
  end

  // delivery monitor: a word counts when decode takes it
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (instr_valid && !stall && !PCsrc) begin
      if (exp_pc.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_instr act=%h exp=none",
                 instr_pc);
      end else begin
        e = exp_pc.pop_front();
        chk("instr_pc", instr_pc, e);
        chk("instr", instr, f(e));
      end
    end
  end

  initial begin
    exp1.push_back(32'hFFFF_FFFC);
    exp1.push_back(32'h0000_0000);
    exp1.push_back(32'h0000_0004);
    cyc(2);
    chk("rst_req_valid", {31'd0, i0.imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", i0.imem_req_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_wrap_addr", i1.imem_req_addr, 32'hFFFF_FFFC);

    // sequential fetches from reset
    for (int k = 0; k < 3; k++) begin
      exp_addr.push_back(32'(4 * k));
      exp_pc.push_back(32'(4 * k));
    end
    i0.imem_req_ready = 1'b1;
    rst  = 1'b0;
    rst1 = 1'b0;
    cyc(9);
    i0.imem_req_ready = 1'b0;
    cyc(3);

    // stall in OUT holds the word
    exp_addr.push_back(32'hC);
    exp_pc.push_back(32'hC);
    i0.imem_req_ready = 1'b1;
    stall = 1'b1;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", instr_pc, 32'hC);
      chk("stall_instr", instr, f(32'hC));
      chk("stall_noreq", {31'd0, i0.imem_req_valid}, 32'd0);
      cyc(1);
    end
    stall = 1'b0;
    cyc(2);

    // redirect while waiting
    lat = 3;
    exp_addr.push_back(32'h10);
    exp_addr.push_back(32'h100);
    i0.imem_req_ready = 1'b1;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    PCsrc = 1'b1;
    branch_target = 32'h100;
    cyc(1);
    PCsrc = 1'b0;
    cyc(4);
    chk("wait_redir_addr", i0.imem_req_addr, 32'h100);
    chk("wait_redir_req", {31'd0, i0.imem_req_valid}, 32'd1);

    // redirect on the accept cycle
    lat = 1;
    exp_addr.push_back(32'h40);
    i0.imem_req_ready = 1'b1;
    PCsrc = 1'b1;
    branch_target = 32'h40;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    PCsrc = 1'b0;
    cyc(3);
    chk("acc_redir_addr", i0.imem_req_addr, 32'h40);
    chk("acc_redir_iv", {31'd0, instr_valid}, 32'd0);

    // redirect in OUT while stalled
    exp_addr.push_back(32'h80);
    exp_pc.push_back(32'h80);
    i0.imem_req_ready = 1'b1;
    stall = 1'b1;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    cyc(1);
    chk("out_hold_pc", instr_pc, 32'h40);
    PCsrc = 1'b1;
    branch_target = 32'h80;
    cyc(1);
    PCsrc = 1'b0;
    chk("out_redir_iv", {31'd0, instr_valid}, 32'd0);
    chk("out_redir_addr", i0.imem_req_addr, 32'h80);
    stall = 1'b0;
    i0.imem_req_ready = 1'b1;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    cyc(4);

    // async reset during WAIT
    lat = 3;
    exp_addr.push_back(32'h84);
    i0.imem_req_ready = 1'b1;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_addr", i0.imem_req_addr, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_instr_pc", instr_pc, 32'h0);
    chk("arst_iv", {31'd0, instr_valid}, 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(4);
    chk("arst_iv_late", {31'd0, instr_valid}, 32'd0);
    lat = 1;
    exp_addr.push_back(32'h0);
    exp_pc.push_back(32'h0);
    i0.imem_req_ready = 1'b1;
    cyc(1);
    i0.imem_req_ready = 1'b0;
    cyc(4);
    chk("final_addr", i0.imem_req_addr, 32'h4);

    chk("addr_q_left", 32'(exp_addr.size()), 32'd0);
    chk("pc_q_left", 32'(exp_pc.size()), 32'd0);
    chk("wrap_q_left", 32'(exp1.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
